// File: rtl/control_pkg.sv
// ============================================================================
// Module  : control_pkg
// Brief   : States, opcodes and control encodings for the multi-cycle control.
// Revision: 1.0
// ============================================================================
`default_nettype none

package control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC_R    = 4'd6,
    ST_EXEC_I    = 4'd7,
    ST_ALU_WB    = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JAL       = 4'd10,
    ST_TRAP      = 4'd11
  } state_t;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_i      = 7'b0010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  localparam logic [3:0] c_alu_add = 4'b0000;
  localparam logic [3:0] c_alu_sub = 4'b0001;
  localparam logic [3:0] c_alu_and = 4'b0010;
  localparam logic [3:0] c_alu_or  = 4'b0011;
  localparam logic [3:0] c_alu_xor = 4'b0100;
  localparam logic [3:0] c_alu_slt = 4'b0101;

  localparam logic [2:0] c_imm_i = 3'b000;
  localparam logic [2:0] c_imm_s = 3'b001;
  localparam logic [2:0] c_imm_b = 3'b010;
  localparam logic [2:0] c_imm_j = 3'b011;

  localparam logic [1:0] c_res_aluout = 2'b00;
  localparam logic [1:0] c_res_mem    = 2'b01;
  localparam logic [1:0] c_res_alu    = 2'b10;

  localparam logic [1:0] c_src_a_pc    = 2'b00;
  localparam logic [1:0] c_src_a_oldpc = 2'b01;
  localparam logic [1:0] c_src_a_rs1   = 2'b10;

  localparam logic [1:0] c_src_b_rs2  = 2'b00;
  localparam logic [1:0] c_src_b_imm  = 2'b01;
  localparam logic [1:0] c_src_b_four = 2'b10;

  localparam logic [1:0] c_cause_none    = 2'b00;
  localparam logic [1:0] c_cause_illegal = 2'b01;
  localparam logic [1:0] c_cause_timeout = 2'b10;

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
// Module  : alu_decoder
// Brief   : Maps func3/func7[5] of R- and I-type instructions to an ALU code.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_decoder
  import control_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       func7_5,
  input  logic       is_r_type,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = c_alu_add;
    case (func3)
      // Immediate forms have no SUB; func7[5] there is part of the immediate.
      3'b000:  alu_control = (is_r_type && func7_5) ? c_alu_sub : c_alu_add;
      3'b111:  alu_control = c_alu_and;
      3'b110:  alu_control = c_alu_or;
      3'b100:  alu_control = c_alu_xor;
      3'b010:  alu_control = c_alu_slt;
      default: alu_control = c_alu_add;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module  : multicycle_control
// Brief   : RV32I multi-cycle control FSM with shared memory port handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control
  import control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int ALU_CTRL_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op,
  input  logic [2:0]            func3,
  input  logic [6:0]            func7,
  input  logic                  alu_zero,
  input  logic                  alu_last_bit,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  adr_source,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [2:0]            imm_source,
  output logic [1:0]            result_source,
  output logic                  retire,
  output logic                  trap,
  output logic [1:0]            trap_cause
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] c_wait_limit = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] c_wait_max   = {CW{1'b1}};

  state_t          r_state, w_next_state;
  logic [CW-1:0]   r_wait_cnt, w_wait_cnt_next;
  logic            r_trap;
  logic [1:0]      r_cause, w_cause_next;
  logic [3:0]      w_alu_ctrl, w_dec_alu;
  logic            w_mem_state, w_waiting, w_timeout, w_taken, w_branch_ok;
  logic            w_unused_func7;

  assign w_unused_func7 = ^{func7[6], func7[4:0]};

  alu_decoder u_alu_decoder (
    .func3       (func3),
    .func7_5     (func7[5]),
    .is_r_type   (r_state == ST_EXEC_R),
    .alu_control (w_dec_alu)
  );

  assign w_mem_state = (r_state == ST_FETCH) || (r_state == ST_MEM_READ) ||
                       (r_state == ST_MEM_WRITE);
  assign w_waiting   = w_mem_state && !mem_ready;
  assign w_timeout   = (MEM_TIMEOUT > 0) && w_waiting && (r_wait_cnt == c_wait_limit);

  always_comb begin
    w_taken     = 1'b0;
    w_branch_ok = 1'b1;
    case (func3)
      3'b000:  w_taken = alu_zero;
      3'b001:  w_taken = !alu_zero;
      3'b100:  w_taken = alu_last_bit;
      3'b101:  w_taken = !alu_last_bit;
      default: w_branch_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_FETCH;
      r_wait_cnt <= '0;
      r_trap     <= 1'b0;
      r_cause    <= c_cause_none;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_next_state == ST_TRAP && r_state != ST_TRAP) begin
        r_trap  <= 1'b1;
        r_cause <= w_cause_next;
      end
    end
  end

  // Counter only advances while a request is stalled in the same state.
  always_comb begin
    w_wait_cnt_next = '0;
    if (w_waiting && w_next_state == r_state)
      w_wait_cnt_next = (r_wait_cnt == c_wait_max) ? r_wait_cnt : r_wait_cnt + 1'b1;
  end

  always_comb begin
    w_next_state  = r_state;
    w_cause_next  = c_cause_none;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_source    = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = c_src_a_pc;
    alu_src_b     = c_src_b_rs2;
    w_alu_ctrl    = c_alu_add;
    imm_source    = c_imm_i;
    result_source = c_res_aluout;
    retire        = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_req       = 1'b1;
        alu_src_b     = c_src_b_four;
        result_source = c_res_alu;
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          w_next_state = ST_DECODE;
        end else if (w_timeout) begin
          w_next_state = ST_TRAP;
          w_cause_next = c_cause_timeout;
        end
      end
      ST_DECODE: begin
        // JAL needs its target in ALU-out; everything else precomputes a branch target.
        alu_src_a  = c_src_a_oldpc;
        alu_src_b  = c_src_b_imm;
        imm_source = (op == c_op_jal) ? c_imm_j : c_imm_b;
        case (op)
          c_op_load, c_op_store: w_next_state = ST_MEM_ADDR;
          c_op_r:                w_next_state = ST_EXEC_R;
          c_op_i:                w_next_state = ST_EXEC_I;
          c_op_branch:           w_next_state = ST_BRANCH;
          c_op_jal:              w_next_state = ST_JAL;
          default: begin
            w_next_state = ST_TRAP;
            w_cause_next = c_cause_illegal;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a    = c_src_a_rs1;
        alu_src_b    = c_src_b_imm;
        imm_source   = (op == c_op_store) ? c_imm_s : c_imm_i;
        w_next_state = (op == c_op_store) ? ST_MEM_WRITE : ST_MEM_READ;
      end
      ST_MEM_READ: begin
        mem_req    = 1'b1;
        adr_source = 1'b1;
        if (mem_ready) begin
          w_next_state = ST_MEM_WB;
        end else if (w_timeout) begin
          w_next_state = ST_TRAP;
          w_cause_next = c_cause_timeout;
        end
      end
      ST_MEM_WB: begin
        reg_write     = 1'b1;
        result_source = c_res_mem;
        retire        = 1'b1;
        w_next_state  = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        adr_source = 1'b1;
        if (mem_ready) begin
          retire       = 1'b1;
          w_next_state = ST_FETCH;
        end else if (w_timeout) begin
          w_next_state = ST_TRAP;
          w_cause_next = c_cause_timeout;
        end
      end
      ST_EXEC_R, ST_EXEC_I: begin
        alu_src_a    = c_src_a_rs1;
        alu_src_b    = (r_state == ST_EXEC_R) ? c_src_b_rs2 : c_src_b_imm;
        w_alu_ctrl   = w_dec_alu;
        w_next_state = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        reg_write     = 1'b1;
        result_source = c_res_aluout;
        retire        = 1'b1;
        w_next_state  = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a  = c_src_a_rs1;
        alu_src_b  = c_src_b_rs2;
        w_alu_ctrl = c_alu_sub;
        if (w_branch_ok) begin
          pc_write      = w_taken;
          result_source = c_res_aluout;
          retire        = 1'b1;
          w_next_state  = ST_FETCH;
        end else begin
          w_next_state = ST_TRAP;
          w_cause_next = c_cause_illegal;
        end
      end
      ST_JAL: begin
        reg_write     = 1'b1;
        pc_write      = 1'b1;
        alu_src_a     = c_src_a_oldpc;
        alu_src_b     = c_src_b_four;
        result_source = c_res_alu;
        retire        = 1'b1;
        w_next_state  = ST_FETCH;
      end
      ST_TRAP: w_next_state = ST_TRAP;
      default: w_next_state = ST_FETCH;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(w_alu_ctrl);
  assign trap        = r_trap;
  assign trap_cause  = r_cause;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module  : tb_multicycle_control
// Brief   : Randomized instruction-level check of multicycle_control.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0, func7 = '0;
  logic [2:0] func3 = '0;
  logic       alu_zero = 1'b0, alu_last_bit = 1'b0, mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_source, ir_write, pc_write, reg_write, retire, trap;
  logic [1:0] alu_src_a, alu_src_b, result_source, trap_cause;
  logic [3:0] alu_control;
  logic [2:0] imm_source;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(4), .ALU_CTRL_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
    .alu_zero(alu_zero), .alu_last_bit(alu_last_bit), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_source(adr_source),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_source(imm_source), .result_source(result_source), .retire(retire),
    .trap(trap), .trap_cause(trap_cause)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks = n_checks + 1;
    if (got != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Instruction classes: 0 load, 1 store, 2 R-type, 3 I-type, 4 branch, 5 jal.
  function automatic logic [6:0] class_op(input int cls);
    case (cls)
      0: return 7'b0000011;
      1: return 7'b0100011;
      2: return 7'b0110011;
      3: return 7'b0010011;
      4: return 7'b1100011;
      default: return 7'b1101111;
    endcase
  endfunction

  function automatic int model_alu(input logic [2:0] f3, input logic f7b, input bit is_r);
    if (f3 == 3'b000) return (is_r && f7b) ? 1 : 0;
    if (f3 == 3'b111) return 2;
    if (f3 == 3'b110) return 3;
    if (f3 == 3'b100) return 4;
    if (f3 == 3'b010) return 5;
    return 0;
  endfunction

  function automatic int model_taken(input logic [2:0] f3, input logic z, input logic lb);
    if (f3 == 3'b000) return int'(z);
    if (f3 == 3'b001) return int'(!z);
    if (f3 == 3'b100) return int'(lb);
    return int'(!lb);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs one instruction from FETCH; fw/mw are wait cycles before ready.
  task automatic run_instr(input int idx, input int cls, input int fw, input int mw,
                           input logic [2:0] f3, input logic [6:0] f7,
                           input logic z, input logic lb);
    bit is_mem = (cls == 0 || cls == 1);
    int len, n_rw = 0, n_mw = 0, n_pw = 0, n_mr = 0, n_ret = 0, n_bad = 0;
    int ret_c = -1, rs_rw = -1, alu_seen = -1, exp_pw;
    case (cls)
      0: len = fw + 5 + mw;
      1: len = fw + 4 + mw;
      2, 3: len = fw + 4;
      default: len = fw + 3;
    endcase
    op = class_op(cls); func3 = f3; func7 = f7; alu_zero = z; alu_last_bit = lb;
    for (int c = 0; c < len; c++) begin
      if (c < fw) mem_ready = 1'b0;
      else if (c == fw) mem_ready = 1'b1;
      else if (is_mem && c >= fw + 3) mem_ready = (c == fw + 3 + mw);
      else mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (reg_write) begin n_rw++; rs_rw = int'(result_source); end
      if (mem_write) n_mw++;
      if (mem_write && !mem_req) n_bad++;
      if (pc_write) n_pw++;
      if (mem_req) n_mr++;
      if (retire) begin n_ret++; ret_c = c; end
      if (c == fw + 2) alu_seen = int'(alu_control);
      next_cycle();
    end
    exp_pw = 1 + ((cls == 5) ? 1 : (cls == 4) ? model_taken(f3, z, lb) : 0);
    check_eq($sformatf("i%0d retire_count", idx), n_ret, 1);
    check_eq($sformatf("i%0d retire_cycle", idx), ret_c, len - 1);
    check_eq($sformatf("i%0d reg_write_count", idx), n_rw, (cls == 0 || cls == 2 || cls == 3 || cls == 5) ? 1 : 0);
    check_eq($sformatf("i%0d mem_write_count", idx), n_mw, (cls == 1) ? mw + 1 : 0);
    check_eq($sformatf("i%0d mem_write_without_req", idx), n_bad, 0);
    check_eq($sformatf("i%0d pc_write_count", idx), n_pw, exp_pw);
    check_eq($sformatf("i%0d mem_req_count", idx), n_mr, fw + 1 + (is_mem ? mw + 1 : 0));
    if (cls == 2 || cls == 3)
      check_eq($sformatf("i%0d alu_control", idx), alu_seen, model_alu(f3, f7[5], cls == 2));
    if (cls == 4)
      check_eq($sformatf("i%0d branch_alu_sub", idx), alu_seen, 1);
    if (cls == 0 || cls == 2 || cls == 3 || cls == 5)
      check_eq($sformatf("i%0d wb_result_source", idx), rs_rw, (cls == 0) ? 1 : (cls == 5) ? 2 : 0);
    check_eq($sformatf("i%0d no_trap", idx), int'(trap), 0);
  endtask

  initial begin
    logic [2:0] br_f3 [4] = '{3'b000, 3'b001, 3'b100, 3'b101};

    // Reset state: only mem_req asserted.
    rst = 1'b1;
    @(negedge clk);
    check_eq("reset mem_req", int'(mem_req), 1);
    check_eq("reset mem_write", int'(mem_write), 0);
    check_eq("reset ir_write", int'(ir_write), 0);
    check_eq("reset pc_write", int'(pc_write), 0);
    check_eq("reset reg_write", int'(reg_write), 0);
    check_eq("reset retire", int'(retire), 0);
    check_eq("reset trap", int'(trap), 0);
    check_eq("reset trap_cause", int'(trap_cause), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed programs: add, lw with 3 waits, branch set, jal, store.
    run_instr(0, 2, 0, 0, 3'b000, 7'b0000000, 1'b0, 1'b0);
    run_instr(1, 0, 0, 3, 3'b010, 7'b0000000, 1'b0, 1'b0);
    run_instr(2, 4, 0, 0, 3'b000, 7'b0, 1'b1, 1'b0);
    run_instr(3, 4, 0, 0, 3'b001, 7'b0, 1'b1, 1'b0);
    run_instr(4, 4, 0, 0, 3'b100, 7'b0, 1'b0, 1'b1);
    run_instr(5, 4, 0, 0, 3'b101, 7'b0, 1'b0, 1'b1);
    run_instr(6, 5, 0, 0, 3'b000, 7'b0, 1'b0, 1'b0);
    run_instr(7, 1, 1, 2, 3'b010, 7'b0, 1'b0, 1'b0);
    run_instr(8, 2, 0, 0, 3'b000, 7'b0100000, 1'b0, 1'b0);
    run_instr(9, 3, 4, 0, 3'b000, 7'b0100000, 1'b0, 1'b0);

    for (int i = 10; i < 70; i++) begin
      int cls = $urandom_range(0, 5);
      logic [2:0] f3 = 3'($urandom_range(0, 7));
      if (cls == 4) f3 = br_f3[$urandom_range(0, 3)];
      run_instr(i, cls, $urandom_range(0, 4), $urandom_range(0, 4), f3,
                7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Illegal opcode: trap after DECODE, enables stay low.
    reset_dut();
    op = 7'b1111111;
    mem_ready = 1'b1;
    next_cycle();
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq($sformatf("illegal_op trap c%0d", c), int'(trap), 1);
      check_eq($sformatf("illegal_op cause c%0d", c), int'(trap_cause), 1);
      check_eq($sformatf("illegal_op enables c%0d", c),
               int'({mem_req, mem_write, ir_write, pc_write, reg_write, retire}), 0);
      next_cycle();
    end

    // Branch with func3 010 is illegal.
    reset_dut();
    op = 7'b1100011; func3 = 3'b010; alu_zero = 1'b1;
    mem_ready = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("bad_branch no_retire", int'({pc_write, retire}), 0);
    next_cycle();
    @(negedge clk);
    check_eq("bad_branch trap", int'(trap), 1);
    check_eq("bad_branch cause", int'(trap_cause), 1);
    check_eq("bad_branch mem_req", int'(mem_req), 0);

    // Fetch timeout with MEM_TIMEOUT=4.
    reset_dut();
    mem_ready = 1'b0;
    for (int c = 0; c < 4; c++) next_cycle();
    @(negedge clk);
    check_eq("timeout not_yet", int'(trap), 0);
    next_cycle();
    @(negedge clk);
    check_eq("timeout trap", int'(trap), 1);
    check_eq("timeout cause", int'(trap_cause), 2);
    check_eq("timeout mem_req", int'(mem_req), 0);

    // Ready on the limit cycle wins.
    reset_dut();
    run_instr(100, 2, 4, 0, 3'b111, 7'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of MEM_WRITE.
    reset_dut();
    op = 7'b0100011; func3 = 3'b010;
    mem_ready = 1'b1;
    next_cycle();
    mem_ready = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("async pre mem_write", int'(mem_write), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("async mem_write_drop", int'(mem_write), 0);
    check_eq("async mem_req_fetch", int'(mem_req), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("async post mem_req", int'(mem_req), 1);
    check_eq("async post mem_write", int'(mem_write), 0);
    check_eq("async post trap", int'(trap), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
